// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared width constants and stage payload types for pipelined_subtractor
package sub_pkg;

  localparam int WIDTH = 8;
  localparam int HALF  = WIDTH / 2;

  // Stage-1 payload: low-half difference plus the untouched upper halves
  typedef struct packed {
    logic [HALF-1:0] d_lo;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;
    logic            b1;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             borrow;
  } res_t;

endpackage

// File: rtl/half_sub_stage.sv
// rtl/half_sub_stage.sv - combinational HALF-bit subtract with borrow in and borrow out
module half_sub_stage
  import sub_pkg::*;
(
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            bin,
  output logic [HALF-1:0] d,
  output logic            bout
);

  // One extra bit holds the sign of a - b - bin, which is exactly the borrow-out
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{HALF{1'b0}}, bin};

endmodule

// File: rtl/pipelined_subtractor.sv
// rtl/pipelined_subtractor.sv - two-stage op1 - op2 with borrow and valid/ready handshakes
// Optional SUB_SATURATE_EN clamps the result to 0 whenever the subtraction borrows.
module pipelined_subtractor
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  logic            s1_valid;
  s1_t             s1_q;
  s1_t             s1_d;
  res_t            res_q;
  res_t            res_d;
  logic            s2_ready;
  logic            s1_adv;
  logic            in_xfer;
  logic            out_xfer;
  logic [HALF-1:0] lo_d;
  logic            lo_b;
  logic [HALF-1:0] hi_d;
  logic            hi_b;

  assign s2_ready = ~out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_ready;
  assign in_ready = ~s1_valid | s2_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  half_sub_stage u_lo (
    .a    (op1[HALF-1:0]),
    .b    (op2[HALF-1:0]),
    .bin  (1'b0),
    .d    (lo_d),
    .bout (lo_b)
  );

  half_sub_stage u_hi (
    .a    (s1_q.a_hi),
    .b    (s1_q.b_hi),
    .bin  (s1_q.b1),
    .d    (hi_d),
    .bout (hi_b)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.d_lo = lo_d;
    s1_d.a_hi = op1[WIDTH-1:HALF];
    s1_d.b_hi = op2[WIDTH-1:HALF];
    s1_d.b1   = lo_b;
  end

  always_comb begin
    res_d        = '0;
    res_d.result = {hi_d, s1_q.d_lo};
    res_d.borrow = hi_b;
`ifdef SUB_SATURATE_EN
    if (hi_b) begin
      res_d.result = '0;
    end
`endif
  end

  // Operands only enter state on a real input transfer, so idle X never reaches s1_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  assign result = res_q.result;
  assign borrow = res_q.borrow;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// tb/tb_pipelined_subtractor.sv - randomized self-checking bench for pipelined_subtractor
module tb_pipelined_subtractor;
  import sub_pkg::*;

  localparam int W = WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         borrow;

  int checks = 0;
  int failures = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] last_res = '0;
  logic         last_brw = 1'b0;
  int           out_count = 0;
  logic         held_valid = 1'b0;
  logic [W-1:0] held_res = '0;
  logic         held_brw = 1'b0;

  always #5 clk = ~clk;

  pipelined_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .borrow    (borrow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, reduced modulo 2^W, optionally clamped
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int           diff;
    logic [W-1:0] res;
    logic         brw;
    diff = int'(a) - int'(b);
    brw  = (a < b);
    res  = diff[W-1:0];
`ifdef SUB_SATURATE_EN
    if (brw) res = '0;
`endif
    return {res, brw};
  endfunction

  // Monitor on the falling edge: scoreboard in/out transfers and stall stability
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    if (!rst_n) begin
      exp_q.delete();
      held_valid <= 1'b0;
    end else begin
      if (held_valid) begin
        check_eq("stall_valid", out_valid, 1'b1);
        check_eq("stall_result", result, held_res);
        check_eq("stall_borrow", borrow, held_brw);
      end
      held_valid <= out_valid & ~out_ready;
      held_res   <= result;
      held_brw   <= borrow;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", result, e[W:1]);
          check_eq("borrow", borrow, e[0]);
          last_res  <= result;
          last_brw  <= borrow;
          out_count <= out_count + 1;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op1, op2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int   n;
    logic acc;
    n = 0;
    op1 = a;
    op2 = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) check_eq("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
    op1 = W'($urandom);
    op2 = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int rv;
    int cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_result", result, 0);
    check_eq("rst_borrow", borrow, 1'b0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    tick();

    // Latency: visible on the second edge after transfer
    out_ready = 1'b1;
    op1 = 8'd200;
    op2 = 8'd55;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_edge1_valid", out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_edge2_valid", out_valid, 1'b1);
    check_eq("lat_result", result, 145);
    check_eq("lat_borrow", borrow, 1'b0);
    tick();

    // Cross-half borrow and wrap-around
    send(8'h10, 8'h01);
    drain();
    check_eq("xhalf_result", last_res, 8'h0F);
    check_eq("xhalf_borrow", last_brw, 1'b0);
    send(8'd5, 8'd10);
    drain();
`ifdef SUB_SATURATE_EN
    check_eq("wrap_result", last_res, 0);
`else
    check_eq("wrap_result", last_res, 251);
`endif
    check_eq("wrap_borrow", last_brw, 1'b1);
    send(8'd255, 8'd255);
    drain();
    check_eq("equal_result", last_res, 0);
    check_eq("equal_borrow", last_brw, 1'b0);

    // Backpressure: two beats fit, third waits for out_ready
    base = out_count;
    out_ready = 1'b0;
    in_valid = 1'b1;
    op1 = 8'd9;
    op2 = 8'd3;
    @(negedge clk);
    check_eq("bp_accept0", in_ready, 1'b1);
    tick();
    op1 = 8'd100;
    op2 = 8'd200;
    @(negedge clk);
    check_eq("bp_accept1", in_ready, 1'b1);
    tick();
    op1 = 8'd77;
    op2 = 8'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_full", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_resume", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    drain();
    check_eq("bp_count", out_count - base, 3);

    // Full-rate stream
    base = out_count;
    for (int i = 0; i < 256; i++) begin
      op1 = W'($urandom);
      op2 = W'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("stream_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    drain();
    check_eq("stream_count", out_count - base, 256);

    // Random valid/ready on both sides
    for (int i = 0; i < 400; i++) begin
      rv = int'($urandom_range(0, 3));
      in_valid = (rv != 0);
      op1 = W'($urandom);
      op2 = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(8'd1, 8'd2);
    send(8'd3, 8'd4);
    @(negedge clk);
    check_eq("rst6_full", out_valid, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst6_drop", out_valid, 1'b0);
    check_eq("rst6_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_eq("rst6_no_stale", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
